wb_bram_ctrl: RTL and testbench
===============================

# wb_bram_ctrl

Wishbone-classic slave that sits directly upstream of the user-project block RAM and translates firmware bus cycles into its single-port BRAM access. It decodes the user address window, stalls each request for a programmable number of wait cycles to emulate slow instruction memory, then issues exactly one BRAM access and returns a single-cycle acknowledge with read data. It is the only driver of the BRAM port pins.

## Interface
- `DELAYS`, default 10: wait cycles inserted before the BRAM access; legal range 0–255.
- `BASE_ADDR`, default 32'h3800_0000: window base; a request hits when `wbs_adr_i[31:24] == BASE_ADDR[31:24]`.
- `wb_clk_i`  in  1  clock; all logic on the rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`  in  1  bus cycle valid.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  1 = write.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid only while `wbs_ack_o` is high, else 0.
- `bram_en`  out  1  BRAM enable (EN0).
- `bram_we`  out  4  BRAM byte write enables (WE0).
- `bram_di`  out  32  BRAM write data (Di0).
- `bram_a`  out  32  BRAM word address (A0) = {20'b0, adr[13:2]}.
- `bram_do`  in  32  BRAM read data (Do0); 1-cycle registered latency, 0 when EN0 low.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: on `wbs_cyc_i & wbs_stb_i & hit`, latch adr, dat, sel, we. Go WAIT with counter = DELAYS-1 if DELAYS>0, else ACCESS. Non-hit requests are ignored (no ack, no state change).
- WAIT: if `!(wbs_cyc_i & wbs_stb_i)` → IDLE (abort, no BRAM access). Else if counter==0 → ACCESS, else decrement.
- ACCESS (exactly 1 cycle): `bram_en`=1, `bram_we` = we ? sel : 4'b0, `bram_di`/`bram_a` from latches. Always → RESP; the access is committed even if the master drops strobe.
- RESP (exactly 1 cycle): `wbs_ack_o = wbs_cyc_i & wbs_stb_i`, `wbs_dat_o = bram_do` for reads, 0 for writes. Always → IDLE.
- Writes with `wbs_sel_i` = 0 still complete and ack; the BRAM is unchanged.
- Counter width: 8 bits; no wrap (loaded only in IDLE).
- Reset in any state: next cycle IDLE. `wbs_ack_o`=0, `wbs_dat_o`=0, `bram_en`=0, `bram_we`=0, `bram_di`=0, `bram_a`=0, counter=0. A reset during ACCESS cannot retract a write already sampled by the BRAM on that edge.

## Timing
- Request first valid in cycle 0 → WAIT cycles 1..DELAYS → ACCESS cycle DELAYS+1 → ack cycle DELAYS+2. Default: ack in cycle 12; DELAYS=0: ack in cycle 2.
- Master drops stb at the edge that samples ack. Controller is in IDLE in the following cycle, so a back-to-back request costs no extra gap cycle: ack-to-next-ack = DELAYS+3 cycles.
- `bram_en` is high for exactly one cycle per completed transaction. BRAM output is 0 in all other cycles.
- `wbs_dat_o` is combinational from `bram_do` in RESP. All other outputs are registered or state-decoded.

## Structure
- Shared package `wb_bram_pkg`: state encoding (2 bits: IDLE=0, WAIT=1, ACCESS=2, RESP=3), window-decode width (8), BRAM word-index width (12).
- One sub-module: `wait_counter`, which is loadable, down-counts, and flags zero. The FSM, latches and decode stay in the top module.

## Test plan
- Write 32'hDEADBEEF, sel 4'hF, adr 32'h3800_0010, DELAYS=10 → `bram_en` high only in cycle 11 with `bram_a`=4 and `bram_we`=4'hF; ack in cycle 12.
- Read back the same address → ack in cycle 12 with `wbs_dat_o`=32'hDEADBEEF, and `wbs_dat_o`=0 in cycles 11 and 13.
- Byte write sel 4'b0100, dat 32'h0055_0000, then read → 32'hDE55BEEF.
- Request at adr 32'h3000_0000 → no ack and no `bram_en` for 20 cycles.
- Drop stb in cycle 5 of WAIT → no `bram_en`, no ack, IDLE in cycle 6. A new request is then served normally.
- Assert reset in cycle 8 of a write, then run DELAYS=0 back-to-back reads → all outputs 0 in the cycle after reset. The memory location is unchanged, and acks arrive every 3 cycles.

Source files
------------

// File: rtl/wb_bram_pkg.sv
// wb_bram_pkg: shared state encoding and field widths for the Wishbone BRAM controller
package wb_bram_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;
  localparam int DEC_W = 8;
  localparam int IDX_W = 12;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable 8-bit down-counter that holds at zero and flags it
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= 8'd0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != 8'd0) cnt <= cnt - 8'd1;
  end
  assign zero = cnt == 8'd0;
endmodule

// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone-classic slave that stalls DELAYS cycles then issues one BRAM access
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter int          DELAYS    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_di,
  output logic [31:0] bram_a,
  input  logic [31:0] bram_do
);
  localparam logic [7:0] LOAD_VAL = (DELAYS == 0) ? 8'd0 : 8'(DELAYS - 1);
  state_t state;
  logic [IDX_W-1:0] idx_l;
  logic [31:0] dat_l;
  logic [3:0] sel_l;
  logic we_l, req, hit, cnt_zero, unused;
  assign req = wbs_cyc_i & wbs_stb_i;
  assign hit = wbs_adr_i[31:32-DEC_W] == BASE_ADDR[31:32-DEC_W];
  assign unused = ^{wbs_adr_i[31-DEC_W:IDX_W+2], wbs_adr_i[1:0]};
  wait_counter u_cnt (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (state == IDLE && req && hit),
    .dec      (state == WAIT && req),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );
  // BRAM pins are registered and only non-zero during the single ACCESS cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      idx_l   <= '0;
      dat_l   <= '0;
      sel_l   <= '0;
      we_l    <= 1'b0;
      bram_en <= 1'b0;
      bram_we <= '0;
      bram_di <= '0;
      bram_a  <= '0;
    end else begin
      bram_en <= 1'b0;
      bram_we <= '0;
      bram_di <= '0;
      bram_a  <= '0;
      case (state)
        IDLE: if (req && hit) begin
          idx_l <= wbs_adr_i[IDX_W+1:2];
          dat_l <= wbs_dat_i;
          sel_l <= wbs_sel_i;
          we_l  <= wbs_we_i;
          if (DELAYS == 0) begin
            state   <= ACCESS;
            bram_en <= 1'b1;
            bram_we <= wbs_we_i ? wbs_sel_i : 4'b0;
            bram_di <= wbs_dat_i;
            bram_a  <= {{(32-IDX_W){1'b0}}, wbs_adr_i[IDX_W+1:2]};
          end else state <= WAIT;
        end
        WAIT: if (!req) state <= IDLE;
        else if (cnt_zero) begin
          state   <= ACCESS;
          bram_en <= 1'b1;
          bram_we <= we_l ? sel_l : 4'b0;
          bram_di <= dat_l;
          bram_a  <= {{(32-IDX_W){1'b0}}, idx_l};
        end
        ACCESS: state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
  assign wbs_ack_o = (state == RESP) & req;
  assign wbs_dat_o = (wbs_ack_o & ~we_l) ? bram_do : 32'd0;
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb_wb_bram_ctrl: directed tests for wb_bram_ctrl with DELAYS=10 and DELAYS=0 instances on one BRAM model
module tb_wb_bram_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cyc, stb, we, cyc0, stb0;
  logic [3:0] sel;
  logic [31:0] adr, dat;
  logic ack, en, ack0, en0;
  logic [3:0] bwe, bwe0;
  logic [31:0] dato, di, a, do10, dato0, di0, a0, do0;
  logic [31:0] mem [0:4095];
  int n_tests = 0, n_fail = 0;
  logic lg_en [0:39];
  logic lg_ack [0:39];
  logic [31:0] lg_dat [0:39];
  logic [31:0] lg_a [0:39];
  logic [31:0] lg_di [0:39];
  logic [3:0] lg_we [0:39];

  wb_bram_ctrl #(.DELAYS(10)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .bram_en(en), .bram_we(bwe), .bram_di(di), .bram_a(a), .bram_do(do10));
  wb_bram_ctrl #(.DELAYS(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb0), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack0), .wbs_dat_o(dato0),
    .bram_en(en0), .bram_we(bwe0), .bram_di(di0), .bram_a(a0), .bram_do(do0));

  // Single-port BRAM per controller, sharing one array; read data registered, 0 when disabled
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (en && bwe[b]) mem[a[11:0]][8*b +: 8] <= di[8*b +: 8];
      if (en0 && bwe0[b]) mem[a0[11:0]][8*b +: 8] <= di0[8*b +: 8];
    end
    do10 <= en ? mem[a[11:0]] : 32'd0;
    do0 <= en0 ? mem[a0[11:0]] : 32'd0;
  end

  task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] ad, input logic [31:0] d,
                      input int ncyc, input int drop_at, input int rst_at);
    bit acked;
    acked = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin cyc = 1; stb = 1; we = w; sel = s; adr = ad; dat = d; end
      if (acked || k == drop_at) begin cyc = 0; stb = 0; end
      rst = (k == rst_at);
      #1;
      lg_en[k] = en; lg_ack[k] = ack; lg_dat[k] = dato; lg_a[k] = a; lg_di[k] = di; lg_we[k] = bwe;
      if (ack) acked = 1'b1;
    end
    cyc = 0; stb = 0; rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; cyc = 0; stb = 0; cyc0 = 0; stb0 = 0; we = 0; sel = 0; adr = 0; dat = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    n_tests++; if ({ack, en, bwe} !== 6'd0) begin n_fail++; $display("FAIL reset_ctrl: ack/en/we=%b required 0", {ack, en, bwe}); end
    n_tests++; if (dato !== 32'd0) begin n_fail++; $display("FAIL reset_dat: got %h required 0", dato); end
    n_tests++; if ({di, a} !== 64'd0) begin n_fail++; $display("FAIL reset_di_a: got %h required 0", {di, a}); end
    n_tests++; if ({ack0, en0, bwe0, di0, a0} !== '0) begin n_fail++; $display("FAIL reset_dut0: nonzero outputs"); end
  endtask

  task automatic test_write;
    xfer(1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 16, -1, -1);
    for (int k = 0; k < 16; k++) begin
      n_tests++; if (lg_en[k] !== (k == 11)) begin n_fail++; $display("FAIL write_en c%0d: got %b required %b", k, lg_en[k], k == 11); end
      n_tests++; if (lg_ack[k] !== (k == 12)) begin n_fail++; $display("FAIL write_ack c%0d: got %b required %b", k, lg_ack[k], k == 12); end
    end
    n_tests++; if (lg_a[11] !== 32'd4) begin n_fail++; $display("FAIL write_addr: got %h required 4", lg_a[11]); end
    n_tests++; if (lg_we[11] !== 4'hF) begin n_fail++; $display("FAIL write_we: got %h required f", lg_we[11]); end
    n_tests++; if (lg_di[11] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_di: got %h required deadbeef", lg_di[11]); end
    n_tests++; if (lg_dat[12] !== 32'd0) begin n_fail++; $display("FAIL write_dato: got %h required 0", lg_dat[12]); end
    n_tests++; if (mem[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_mem: got %h required deadbeef", mem[4]); end
  endtask

  task automatic test_read;
    xfer(0, 4'hF, 32'h3800_0010, 32'd0, 16, -1, -1);
    n_tests++; if (lg_ack[12] !== 1'b1 || lg_ack[11] !== 1'b0) begin n_fail++; $display("FAIL read_ack: c11=%b c12=%b required 0 1", lg_ack[11], lg_ack[12]); end
    n_tests++; if (lg_dat[12] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_dat: got %h required deadbeef", lg_dat[12]); end
    n_tests++; if (lg_dat[11] !== 32'd0 || lg_dat[13] !== 32'd0) begin n_fail++; $display("FAIL read_dat_edges: c11=%h c13=%h required 0", lg_dat[11], lg_dat[13]); end
    n_tests++; if (lg_en[11] !== 1'b1 || lg_we[11] !== 4'h0) begin n_fail++; $display("FAIL read_access: en=%b we=%h required 1 0", lg_en[11], lg_we[11]); end
  endtask

  task automatic test_byte_write;
    xfer(1, 4'b0100, 32'h3800_0010, 32'h0055_0000, 16, -1, -1);
    n_tests++; if (lg_we[11] !== 4'b0100) begin n_fail++; $display("FAIL byte_we: got %b required 0100", lg_we[11]); end
    xfer(0, 4'hF, 32'h3800_0010, 32'd0, 16, -1, -1);
    n_tests++; if (lg_dat[12] !== 32'hDE55_BEEF) begin n_fail++; $display("FAIL byte_read: got %h required de55beef", lg_dat[12]); end
  endtask

  task automatic test_miss;
    int bad;
    xfer(0, 4'hF, 32'h3000_0000, 32'd0, 21, -1, -1);
    bad = 0;
    for (int k = 0; k < 21; k++) if (lg_en[k] !== 1'b0 || lg_ack[k] !== 1'b0) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL miss: %0d cycles with en/ack, required 0", bad); end
  endtask

  task automatic test_abort;
    int bad;
    xfer(0, 4'hF, 32'h3800_0010, 32'd0, 16, 5, -1);
    bad = 0;
    for (int k = 0; k < 16; k++) if (lg_en[k] !== 1'b0 || lg_ack[k] !== 1'b0) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL abort: %0d cycles with en/ack, required 0", bad); end
    xfer(0, 4'hF, 32'h3800_0010, 32'd0, 16, -1, -1);
    n_tests++; if (lg_ack[12] !== 1'b1 || lg_dat[12] !== 32'hDE55_BEEF) begin n_fail++; $display("FAIL abort_next: ack=%b dat=%h required 1 de55beef", lg_ack[12], lg_dat[12]); end
  endtask

  task automatic test_back_to_back;
    int nack;
    xfer(1, 4'hF, 32'h3800_0010, 32'h1234_5678, 10, 8, 8);
    n_tests++; if ({lg_en[9], lg_ack[9], lg_we[9]} !== 6'd0) begin n_fail++; $display("FAIL rst_ctrl: got %b required 0", {lg_en[9], lg_ack[9], lg_we[9]}); end
    n_tests++; if ({lg_dat[9], lg_a[9], lg_di[9]} !== 96'd0) begin n_fail++; $display("FAIL rst_data: got %h required 0", {lg_dat[9], lg_a[9], lg_di[9]}); end
    n_tests++; if (mem[4] !== 32'hDE55_BEEF) begin n_fail++; $display("FAIL rst_mem: got %h required de55beef", mem[4]); end
    nack = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin cyc0 = 1; stb0 = 1; we = 0; sel = 4'hF; adr = 32'h3800_0010; end
      #1;
      n_tests++; if (ack0 !== (k % 3 == 2)) begin n_fail++; $display("FAIL b2b_ack c%0d: got %b required %b", k, ack0, k % 3 == 2); end
      if (ack0) begin
        nack++;
        n_tests++; if (dato0 !== 32'hDE55_BEEF) begin n_fail++; $display("FAIL b2b_dat c%0d: got %h required de55beef", k, dato0); end
      end
    end
    cyc0 = 0; stb0 = 0;
    n_tests++; if (nack != 3) begin n_fail++; $display("FAIL b2b_count: got %0d required 3", nack); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    test_reset;
    test_write;
    test_read;
    test_byte_write;
    test_miss;
    test_abort;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
